// File: rtl/alp_cmd_sequencer.sv
// alp_cmd_sequencer
// Initiator side of the arithmetic logic processor Controller interface.
// Takes one operation (opcode + two operands) over a valid/ready handshake,
// issues CLR / LOAD(a) / LOAD(b) / COMP to the Controller, waits for done
// (bounded by a timeout), captures R0/R1 and presents them on a valid/ready
// result port. Every control output comes straight from a flop.

module alp_cmd_sequencer #(
    parameter int         W       = 4,
    parameter logic [2:0] OP_DIV  = 3'b001,
    parameter int         TMO_CYC = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    // command port
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    // Controller / datapath side
    output logic [W-1:0] Datain,
    output logic         LOAD,
    output logic         CLR,
    output logic         COMP,
    output logic [2:0]   OP,
    input  logic         done,
    input  logic [W-1:0] R0in,
    input  logic [W-1:0] R1in,
    // result port
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_r0,
    output logic [W-1:0] res_r1,
    output logic         res_err,
    output logic         busy
);

    // Counter holds the number of cycles elapsed since the COMP pulse.
    localparam int             CW      = $clog2(TMO_CYC) + 1;
    localparam logic [CW-1:0]  CNT_EXP = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0]  CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOADA,
        S_LOADB,
        S_EXEC,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [2:0]    op_reg;
    logic [2:0]    op_next;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  a_next;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  b_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // Next values of the registered outputs
    logic [W-1:0]  datain_next;
    logic [2:0]    op_out_next;
    logic [W-1:0]  r0_next;
    logic [W-1:0]  r1_next;
    logic          err_next;

    logic          div_by_zero;

    assign div_by_zero = (op_reg == OP_DIV) && (b_reg == '0);

    // State and operand registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic plus next values for operands, counter and result
    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        cnt_next    = cnt_reg;
        r0_next     = res_r0;
        r1_next     = res_r1;
        err_next    = res_err;

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_next    = cmd_op;
                    a_next     = cmd_a;
                    b_next     = cmd_b;
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_next = S_LOADA;
            end
            S_LOADA: begin
                state_next = S_LOADB;
            end
            S_LOADB: begin
                if (div_by_zero) begin
                    // Skip the computation entirely; report error with zeroed data
                    err_next   = 1'b1;
                    r0_next    = '0;
                    r1_next    = '0;
                    state_next = S_RESULT;
                end else begin
                    cnt_next   = '0;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                // COMP cycle itself counts as the first elapsed cycle
                cnt_next   = cnt_reg + CW'(1);
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    // done beats a coincident timeout
                    r0_next    = R0in;
                    r1_next    = R1in;
                    err_next   = 1'b0;
                    state_next = S_RESULT;
                end else if (cnt_reg == CNT_EXP) begin
                    r0_next    = '0;
                    r1_next    = '0;
                    err_next   = 1'b1;
                    state_next = S_RESULT;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_RESULT: begin
                if (res_valid && res_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datain and OP only move when the load states are entered
    always_comb begin
        datain_next = Datain;
        op_out_next = OP;
        if (state_next == S_LOADA && state_reg != S_LOADA) begin
            datain_next = a_reg;
            op_out_next = op_reg;
        end else if (state_next == S_LOADB && state_reg != S_LOADB) begin
            datain_next = b_reg;
        end
    end

    // Output registers, decoded from the state being entered so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            CLR       <= 1'b0;
            LOAD      <= 1'b0;
            COMP      <= 1'b0;
            Datain    <= '0;
            OP        <= '0;
            res_valid <= 1'b0;
            res_r0    <= '0;
            res_r1    <= '0;
            res_err   <= 1'b0;
        end else begin
            cmd_ready <= (state_next == S_IDLE);
            busy      <= (state_next != S_IDLE);
            CLR       <= (state_next == S_CLEAR);
            LOAD      <= (state_next == S_LOADA) || (state_next == S_LOADB);
            COMP      <= (state_next == S_EXEC);
            Datain    <= datain_next;
            OP        <= op_out_next;
            res_valid <= (state_next == S_RESULT);
            res_r0    <= r0_next;
            res_r1    <= r1_next;
            res_err   <= err_next;
        end
    end

endmodule
